// File: rtl/uart_rx_if.sv
// uart_rx_if: bundles the serial line and the received-byte outputs of uart_rx.
// The slave modport is the receiver side; the master modport is the line
// driver / byte consumer side. Optional parity support is selected with the
// UART_RX_PARITY_EN macro, which adds the parity_err signal.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    modport master (
        output rx,
        input  data,
        input  rx_valid,
        input  frame_err,
        input  rx_busy
`ifdef UART_RX_PARITY_EN
        , input parity_err
`endif
    );

    modport slave (
        input  rx,
        output data,
        output rx_valid,
        output frame_err,
        output rx_busy
`ifdef UART_RX_PARITY_EN
        , output parity_err
`endif
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling and one-cycle result strobes.
// The line is double-flopped, a start bit is qualified at its centre, then each
// data bit and the stop bit are sampled one bit period apart. A low stop bit
// reports frame_err and waits for the line to return high before re-arming.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit between
// bit 7 and the stop bit, and a parity_err strobe.
module uart_rx #(
    parameter int BAUD_RATE   = 115_200,
    parameter int CLOCK_SPEED = 50_000_000,
    parameter int BAUD_WIDTH  = int'(CLOCK_SPEED / BAUD_RATE)
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);

    localparam int CW = $clog2(BAUD_WIDTH);
    localparam int HALF = BAUD_WIDTH / 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_WIDTH - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

`ifdef UART_RX_PARITY_EN
    typedef enum logic [5:0] {
        IDLE      = 6'b000001,
        START     = 6'b000010,
        DATA      = 6'b000100,
        PARITY    = 6'b001000,
        STOP      = 6'b010000,
        WAIT_IDLE = 6'b100000
    } state_t;

    // Even parity holds when data bits plus parity bit contain an even count of ones.
    function automatic logic even_parity_ok(input logic [7:0] d, input logic p);
        return ~(^{d, p});
    endfunction
`else
    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        START     = 5'b00010,
        DATA      = 5'b00100,
        STOP      = 5'b01000,
        WAIT_IDLE = 5'b10000
    } state_t;
`endif

    logic          rx_meta_r;
    logic          rxs_r;
    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [2:0]    bit_idx_r, bit_idx_s;
    logic [7:0]    shift_r, shift_s;
    logic [7:0]    data_r, data_s;
    logic          rx_valid_r, rx_valid_s;
    logic          frame_err_r, frame_err_s;
    logic          rx_busy_r, rx_busy_s;
`ifdef UART_RX_PARITY_EN
    logic          parity_r, parity_s;
    logic          parity_err_r, parity_err_s;
`endif

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rxs_r     <= 1'b1;
        end else begin
            rx_meta_r <= bus.rx;
            rxs_r     <= rx_meta_r;
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= CNT_ZERO;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'h00;
            data_r       <= 8'h00;
            rx_valid_r   <= 1'b0;
            frame_err_r  <= 1'b0;
            rx_busy_r    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_r     <= 1'b0;
            parity_err_r <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            bit_idx_r    <= bit_idx_s;
            shift_r      <= shift_s;
            data_r       <= data_s;
            rx_valid_r   <= rx_valid_s;
            frame_err_r  <= frame_err_s;
            rx_busy_r    <= rx_busy_s;
`ifdef UART_RX_PARITY_EN
            parity_r     <= parity_s;
            parity_err_r <= parity_err_s;
`endif
        end
    end

    // Next-state and next-output logic; the bit timer free-runs and wraps each bit period.
    always_comb begin
        state_s      = state_r;
        cnt_s        = (cnt_r == CNT_LAST) ? CNT_ZERO : (cnt_r + CNT_ONE);
        bit_idx_s    = bit_idx_r;
        shift_s      = shift_r;
        data_s       = data_r;
        rx_valid_s   = 1'b0;
        frame_err_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_s     = parity_r;
        parity_err_s = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                cnt_s = CNT_ZERO;
                if (!rxs_r) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                // Start bit is re-checked at its centre to reject glitches.
                if (cnt_r == CNT_HALF) begin
                    cnt_s = CNT_ZERO;
                    if (rxs_r) begin
                        state_s = IDLE;
                    end else begin
                        state_s   = DATA;
                        bit_idx_s = 3'd0;
                    end
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (cnt_r == CNT_LAST) begin
                    shift_s   = {rxs_r, shift_r[7:1]};
                    bit_idx_s = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_s = PARITY;
`else
                        state_s = STOP;
`endif
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_r == CNT_LAST) begin
                    parity_s = rxs_r;
                    state_s  = STOP;
                end else begin
                    state_s = PARITY;
                end
            end
`endif
            STOP: begin
                if (cnt_r == CNT_LAST) begin
                    if (rxs_r) begin
                        state_s = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (even_parity_ok(shift_r, parity_r)) begin
                            data_s     = shift_r;
                            rx_valid_s = 1'b1;
                        end else begin
                            parity_err_s = 1'b1;
                        end
`else
                        data_s     = shift_r;
                        rx_valid_s = 1'b1;
`endif
                    end else begin
                        // Low stop bit: report and wait out a possible break.
                        frame_err_s = 1'b1;
                        state_s     = WAIT_IDLE;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            WAIT_IDLE: begin
                cnt_s = CNT_ZERO;
                if (rxs_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_IDLE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
        rx_busy_s = (state_s != IDLE);
    end

    assign bus.data       = data_r;
    assign bus.rx_valid   = rx_valid_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.rx_busy    = rx_busy_r;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_r;
`endif

endmodule
